// File: rtl/loop_addr_gen.sv
// Address generator fed by an upstream two-level loop nest: maps each (iter1, iter0) tuple to
// BASE + iter1*STRIDE1 + iter0*STRIDE0 through a product stage and a 4-entry output FIFO.
module loop_addr_gen #(
   parameter int unsigned         ITER_W  = 4,
   parameter int unsigned         ADDR_W  = 16,
   parameter logic [ADDR_W-1:0]   BASE    = '0,
   parameter int unsigned         STRIDE0 = 1,
   parameter int unsigned         STRIDE1 = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   output logic              loop_init,
   output logic              enable,
   input  logic [ITER_W-1:0] iter0,
   input  logic [ITER_W-1:0] iter1,
   input  logic              iter_last,
   output logic              addr_valid,
   input  logic              addr_ready,
   output logic [ADDR_W-1:0] addr,
   output logic              addr_last,
   output logic              done
);

   localparam int unsigned Depth = 4;

   typedef enum logic [1:0] {StIdle, StRun, StDrain} state_e;

   state_e state_q, state_d;
   logic   loop_init_q, loop_init_d;
   logic   done_q, done_d;

   logic              p1_valid_q;
   logic              p1_last_q;
   logic [ADDR_W-1:0] p1_prod0_q, p1_prod1_q;

   logic [ADDR_W-1:0] fifo_addr_q [Depth];
   logic [Depth-1:0]  fifo_last_q;
   logic [1:0]        wr_ptr_q, rd_ptr_q;
   logic [2:0]        fifo_cnt_q, fifo_cnt_d;

   logic push, pop, head_last;

   assign push       = p1_valid_q;
   assign addr_valid = (fifo_cnt_q != 3'd0);
   assign pop        = addr_valid && addr_ready;
   assign head_last  = fifo_last_q[rd_ptr_q];

   // FSM state register
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= StIdle;
         loop_init_q <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         loop_init_q <= loop_init_d;
         done_q      <= done_d;
      end
   end

   // FSM next state
   always_comb begin
      state_d     = state_q;
      loop_init_d = 1'b0;
      done_d      = 1'b0;
      case (state_q)
         StIdle: begin
            if (start) begin
               state_d     = StRun;
               loop_init_d = 1'b1;
            end
         end
         StRun: begin
            if (enable && iter_last) state_d = StDrain;
         end
         StDrain: begin
            if (pop && head_last) begin
               state_d = StIdle;
               done_d  = 1'b1;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   // FSM outputs; enable depends on registered state only, so no path from addr_ready
   always_comb begin
      loop_init = loop_init_q;
      done      = done_q;
      enable    = (state_q == StRun) && !loop_init_q &&
                  ((fifo_cnt_q + {2'b00, p1_valid_q}) < 3'(Depth));
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         p1_valid_q <= 1'b0;
      end else begin
         p1_valid_q <= enable;
      end
   end

   always_ff @(posedge clk) begin
      if (enable) begin
         p1_last_q  <= iter_last;
         p1_prod0_q <= ADDR_W'(iter0) * ADDR_W'(STRIDE0);
         p1_prod1_q <= ADDR_W'(iter1) * ADDR_W'(STRIDE1);
      end
   end

   always_comb begin
      fifo_cnt_d = fifo_cnt_q;
      case ({push, pop})
         2'b10:   fifo_cnt_d = fifo_cnt_q + 3'd1;
         2'b01:   fifo_cnt_d = fifo_cnt_q - 3'd1;
         default: fifo_cnt_d = fifo_cnt_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q   <= 2'd0;
         rd_ptr_q   <= 2'd0;
         fifo_cnt_q <= 3'd0;
      end else begin
         if (push) wr_ptr_q <= wr_ptr_q + 2'd1;
         if (pop)  rd_ptr_q <= rd_ptr_q + 2'd1;
         fifo_cnt_q <= fifo_cnt_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         fifo_addr_q[wr_ptr_q] <= BASE + p1_prod1_q + p1_prod0_q;
         fifo_last_q[wr_ptr_q] <= p1_last_q;
      end
   end

   // Storage is not reset, so mask the head while the FIFO is empty
   assign addr      = addr_valid ? fifo_addr_q[rd_ptr_q] : '0;
   assign addr_last = addr_valid && head_last;

endmodule

// File: tb/tb_loop_addr_gen.sv
// Scoreboard bench for loop_addr_gen: a default instance and a BASE=16'hFFFE instance share one
// behavioural upstream loop nest; a monitor pops expected addresses on every transfer.
module tb_loop_addr_gen;

   localparam int unsigned IW = 4;
   localparam int unsigned AW = 16;

   typedef struct packed {
      logic [AW-1:0] a;
      logic          last;
   } exp_t;

   logic          clk = 1'b0;
   logic          rst, start, addr_ready;
   logic [IW-1:0] iter0, iter1;
   logic          iter_last;
   logic          loop_init, enable, addr_valid, addr_last, done;
   logic [AW-1:0] addr;
   logic          loop_init_w, enable_w, addr_valid_w, addr_last_w, done_w;
   logic [AW-1:0] addr_w;

   int n_cmp = 0;
   int n_err = 0;
   int max0 = 3;
   int max1 = 2;
   int acc_cnt = 0;
   int xfer_cnt = 0;
   int li_cnt = 0;
   int overlap_cnt = 0;
   int li_base;

   exp_t q [2][$];

   always #5 clk = ~clk;

   loop_addr_gen #(
      .ITER_W(IW), .ADDR_W(AW), .BASE(16'h0000), .STRIDE0(1), .STRIDE1(4)
   ) dut (
      .clk(clk), .rst(rst), .start(start), .loop_init(loop_init), .enable(enable),
      .iter0(iter0), .iter1(iter1), .iter_last(iter_last), .addr_valid(addr_valid),
      .addr_ready(addr_ready), .addr(addr), .addr_last(addr_last), .done(done)
   );

   loop_addr_gen #(
      .ITER_W(IW), .ADDR_W(AW), .BASE(16'hFFFE), .STRIDE0(1), .STRIDE1(4)
   ) dut_w (
      .clk(clk), .rst(rst), .start(start), .loop_init(loop_init_w), .enable(enable_w),
      .iter0(iter0), .iter1(iter1), .iter_last(iter_last), .addr_valid(addr_valid_w),
      .addr_ready(addr_ready), .addr(addr_w), .addr_last(addr_last_w), .done(done_w)
   );

   task automatic check(input string name, input longint act, input longint exp);
      n_cmp++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Expected addresses for a full nest, computed from the default strides (inner 1, outer 4)
   task automatic push_pass(input int m0, input int m1);
      exp_t e;
      max0 = m0;
      max1 = m1;
      for (int i1 = 0; i1 <= m1; i1++) begin
         for (int i0 = 0; i0 <= m0; i0++) begin
            e.last = (i0 == m0) && (i1 == m1);
            e.a    = AW'(i1 * 4 + i0);
            q[0].push_back(e);
            e.a    = AW'(32'hFFFE + i1 * 4 + i0);
            q[1].push_back(e);
         end
      end
   endtask

   task automatic pulse_start();
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   task automatic wait_done(input string name, input int bound);
      int k;
      k = 0;
      @(negedge clk);
      while (done !== 1'b1 && k < bound) begin
         @(negedge clk);
         k++;
      end
      check({name, "_done"}, done, 1);
      @(posedge clk); #1;
      check({name, "_drained0"}, q[0].size(), 0);
      check({name, "_drained1"}, q[1].size(), 0);
   endtask

   // Upstream loop nest: reinitialised by loop_init, advances on each enable cycle
   assign iter_last = (iter0 == IW'(max0)) && (iter1 == IW'(max1));

   initial begin
      logic up_en, up_li;
      iter0 = '0;
      iter1 = '0;
      forever begin
         @(negedge clk);
         up_en = enable;
         up_li = loop_init;
         if (up_en && up_li) overlap_cnt++;
         if (up_li) li_cnt++;
         @(posedge clk); #1;
         if (up_li) begin
            iter0 = '0;
            iter1 = '0;
         end else if (up_en) begin
            acc_cnt++;
            if (iter0 == IW'(max0)) begin
               iter0 = '0;
               iter1 = iter1 + 1'b1;
            end else begin
               iter0 = iter0 + 1'b1;
            end
         end
      end
   end

   // Monitor for both instances
   logic [1:0]    m_valid, m_last, m_done, hold_v, exp_done;
   logic [AW-1:0] m_addr [2];
   logic [AW-1:0] hold_a [2];
   assign m_valid   = {addr_valid_w, addr_valid};
   assign m_last    = {addr_last_w, addr_last};
   assign m_done    = {done_w, done};
   assign m_addr[0] = addr;
   assign m_addr[1] = addr_w;

   initial begin
      exp_t e;
      hold_v   = '0;
      exp_done = '0;
      forever begin
         @(negedge clk);
         for (int k = 0; k < 2; k++) begin
            if (rst) begin
               hold_v[k]   = 1'b0;
               exp_done[k] = 1'b0;
            end else begin
               if (exp_done[k] || m_done[k])
                  check($sformatf("done%0d", k), m_done[k], exp_done[k]);
               exp_done[k] = 1'b0;
               if (hold_v[k] && m_valid[k])
                  check($sformatf("hold%0d", k), m_addr[k], hold_a[k]);
               hold_v[k] = m_valid[k] && !addr_ready;
               hold_a[k] = m_addr[k];
               if (m_valid[k] && addr_ready) begin
                  if (q[k].size() == 0) begin
                     n_cmp++;
                     n_err++;
                     $display("FAIL extra%0d: got addr %0h, expected no transfer", k, m_addr[k]);
                  end else begin
                     e = q[k].pop_front();
                     check($sformatf("addr%0d", k), m_addr[k], e.a);
                     check($sformatf("last%0d", k), m_last[k], e.last);
                     exp_done[k] = e.last;
                     if (k == 0) xfer_cnt++;
                  end
               end
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL timeout: got no finish, expected finish");
      $fatal(1, "timeout");
   end

   initial begin
      int k;
      rst        = 1'b1;
      start      = 1'b0;
      addr_ready = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_loop_init", loop_init, 0);
      check("rst_enable", enable, 0);
      check("rst_valid", addr_valid, 0);
      check("rst_addr", addr, 0);
      check("rst_last", addr_last, 0);
      check("rst_done", done, 0);
      check("rst_valid_w", addr_valid_w, 0);
      @(posedge clk); #1;
      rst = 1'b0;

      // Plain pass: 0..11, last on 11
      push_pass(3, 2);
      li_base = li_cnt;
      pulse_start();
      wait_done("passA", 100);
      check("passA_li", li_cnt - li_base, 1);

      // Backpressure mid-pass
      push_pass(3, 2);
      li_base = li_cnt;
      pulse_start();
      repeat (4) @(posedge clk); #1;
      addr_ready = 1'b0;
      repeat (10) @(posedge clk);
      @(negedge clk);
      check("stall_enable", enable, 0);
      check("stall_outstanding", acc_cnt - xfer_cnt, 4);
      @(posedge clk); #1;
      addr_ready = 1'b1;
      wait_done("passB", 100);
      check("passB_li", li_cnt - li_base, 1);

      // Start during RUN is ignored
      push_pass(3, 2);
      li_base = li_cnt;
      pulse_start();
      repeat (3) @(posedge clk); #1;
      pulse_start();
      wait_done("passC", 100);
      check("passC_li", li_cnt - li_base, 1);

      // Reset with entries pending, then a fresh pass
      push_pass(3, 2);
      addr_ready = 1'b0;
      pulse_start();
      k = 0;
      @(negedge clk);
      while ((acc_cnt - xfer_cnt) < 3 && k < 50) begin
         @(negedge clk);
         k++;
      end
      check("pre_rst_pending", (acc_cnt - xfer_cnt) >= 3, 1);
      @(posedge clk); #1;
      rst = 1'b1;
      q[0].delete();
      q[1].delete();
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      check("post_rst_valid", addr_valid, 0);
      check("post_rst_enable", enable, 0);
      check("post_rst_valid_w", addr_valid_w, 0);
      @(posedge clk); #1;
      addr_ready = 1'b1;
      push_pass(3, 2);
      pulse_start();
      wait_done("passD", 100);

      // Single-tuple nest
      push_pass(0, 0);
      pulse_start();
      wait_done("passE", 50);

      check("init_enable_overlap", overlap_cnt, 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/loop_addr_gen.md
LOOP_ADDR_GEN -- requirements
Module: loop_addr_gen

Interface
REQ-001 SHALL have parameter ITER_W, default 4, width of each loop iterator.
REQ-002 SHALL have parameter ADDR_W, default 16, address width.
REQ-003 SHALL have parameter BASE, default 0, start address.
REQ-004 SHALL have parameter STRIDE0, default 1, inner-iterator stride.
REQ-005 SHALL have parameter STRIDE1, default 4, outer-iterator stride.
REQ-006 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-007 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-008 SHALL have port start  input  1  one-cycle pulse; begins a new loop-nest pass.
REQ-009 SHALL have port loop_init  output  1  one-cycle pulse reinitialising the upstream loop nest.
REQ-010 SHALL have port enable  output  1  advance request to the upstream loop nest; tuple consumed on every cycle enable=1.
REQ-011 SHALL have port iter0  input  ITER_W  inner iterator value of current tuple.
REQ-012 SHALL have port iter1  input  ITER_W  outer iterator value of current tuple.
REQ-013 SHALL have port iter_last  input  1  current tuple is the final tuple of the nest.
REQ-014 SHALL have port addr_valid  output  1  addr/addr_last valid.
REQ-015 SHALL have port addr_ready  input  1  downstream accepts; transfer when addr_valid & addr_ready.
REQ-016 SHALL have port addr  output  ADDR_W  generated address.
REQ-017 SHALL have port addr_last  output  1  marks address generated from the iter_last tuple.
REQ-018 SHALL have port done  output  1  one-cycle pulse when the pass is fully delivered.

Function
REQ-019 SHALL implement FSM states IDLE, RUN, DRAIN.
REQ-020 SHALL, in IDLE with start=1, pulse loop_init for exactly that next cycle and enter RUN; start in RUN or DRAIN SHALL be ignored.
REQ-021 SHALL never assert enable in IDLE, DRAIN, or the cycle loop_init is high.
REQ-022 SHALL, in RUN, drive enable = (fifo_count + p1_valid) < 4, a function of registered state only (no combinational path from addr_ready).
REQ-023 SHALL, on a cycle with enable=1, capture {iter0, iter1, iter_last} into pipeline stage P1 (p1_valid=1) and compute products iter1*STRIDE1, iter0*STRIDE0.
REQ-024 SHALL, the following edge, write BASE + iter1*STRIDE1 + iter0*STRIDE0, truncated modulo 2^ADDR_W, plus last flag, into a 4-entry output FIFO.
REQ-025 SHALL, with FIFO empty, present addr_valid=1 in the second cycle after the accepting cycle (latency 2 cycles).
REQ-026 SHALL deliver addresses in tuple order, none dropped or duplicated; FIFO SHALL never overflow; simultaneous push and pop SHALL leave fifo_count unchanged.
REQ-027 SHALL hold addr/addr_last stable while addr_valid=1 and addr_ready=0.
REQ-028 SHALL move RUN -> DRAIN on the cycle a tuple with iter_last=1 is accepted; enable low thereafter.
REQ-029 SHALL, in DRAIN, pulse done for one cycle on the cycle after the addr_last transfer, then return to IDLE.

Reset
REQ-030 SHALL, on rst=1 at a rising edge, enter IDLE, clear p1_valid and fifo_count; outputs loop_init, enable, addr_valid, addr_last, done = 0, addr = 0.
REQ-031 SHALL give rst priority over start and all handshakes, including mid-RUN or mid-DRAIN; in-flight addresses are discarded.

Verification
REQ-032 Default params, iter0 0..3 inner, iter1 0..2 outer, addr_ready=1 -> 12 addresses 0..11 in order, addr_last only on 11, done one cycle after.
REQ-033 addr_ready=0 for 10 cycles mid-pass -> enable falls after 4 outstanding entries, resumes on ready; sequence 0..11 complete, no loss.
REQ-034 BASE=16'hFFFE, tuple iter1=0, iter0=3 -> addr=16'h0001 (wrap).
REQ-035 start pulsed during RUN -> no second loop_init, sequence unaffected.
REQ-036 rst asserted with 3 FIFO entries pending -> next cycle addr_valid=0, enable=0; new start yields fresh sequence from BASE.
REQ-037 Single-tuple nest (iter_last=1 on first tuple, iter0=iter1=0) -> one address BASE with addr_last=1, then done.
